nbit_sixtyfour_way_demux_reg: RTL and testbench

NBIT_SIXTYFOUR_WAY_DEMUX_REG -- requirements
Module: nbit_sixtyfour_way_demux_reg

---
 rtl/nbit_sixtyfour_way_demux_reg.sv | 77 +++++++
 tb/tb_nbit_sixtyfour_way_demux_reg.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/nbit_sixtyfour_way_demux_reg.sv
// nbit_sixtyfour_way_demux_reg: 64-slot register bank written through a 1:64 demux, with a fill/hold handshake.
// Define DEMUX64_AUTOINC_EN to enable the auto-incrementing internal write pointer.
module nbit_sixtyfour_way_demux_reg #(
    parameter int N = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    D,
    input  logic [5:0]      S,
    input  logic            auto,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            release_i,
    output logic [64*N-1:0] F,
    output logic [63:0]     vmask,
    output logic            full,
    output logic [5:0]      wr_ptr
);
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [63:0][N-1:0] slot_q, slot_d;
    logic [63:0]        vmask_q, vmask_d;
    logic [5:0]         ptr_q, ptr_d;
    logic [5:0]         idx;
    logic               accept;

`ifdef DEMUX64_AUTOINC_EN
    assign idx = auto ? ptr_q : S;
`else
    logic unused_auto;
    assign unused_auto = auto;
    assign idx         = S;
`endif

    assign accept = in_valid && (state_q == FILL) && !release_i;

    // release beats a same-cycle write; slot data survives a release.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        vmask_d = vmask_q;
        ptr_d   = ptr_q;
        if (release_i) begin
            vmask_d = '0;
            ptr_d   = '0;
            state_d = FILL;
        end else if (accept) begin
            slot_d[idx]  = D;
            vmask_d[idx] = 1'b1;
`ifdef DEMUX64_AUTOINC_EN
            if (auto) ptr_d = ptr_q + 6'd1;
`endif
            if (&vmask_d) state_d = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            slot_q  <= '0;
            vmask_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            vmask_q <= vmask_d;
            ptr_q   <= ptr_d;
        end
    end

    assign F        = slot_q;
    assign vmask    = vmask_q;
    assign full     = (state_q == HOLD);
    assign in_ready = (state_q == FILL);
    assign wr_ptr   = ptr_q;
endmodule

// File: tb/tb_nbit_sixtyfour_way_demux_reg.sv
// Bench for nbit_sixtyfour_way_demux_reg (N=8): vector table, directed corner sequences, random vs. reference model.
module tb_nbit_sixtyfour_way_demux_reg;
    localparam int N = 8;
`ifdef DEMUX64_AUTOINC_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, auto, in_valid, in_ready, release_i, full;
    logic [N-1:0]    D;
    logic [5:0]      S, wr_ptr;
    logic [64*N-1:0] F;
    logic [63:0]     vmask;

    nbit_sixtyfour_way_demux_reg #(.N(N)) dut (
        .clk(clk), .rst(rst), .D(D), .S(S), .auto(auto), .in_valid(in_valid),
        .in_ready(in_ready), .release_i(release_i), .F(F), .vmask(vmask),
        .full(full), .wr_ptr(wr_ptr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain arrays of slot contents and written flags.
    logic [N-1:0] m_mem [64];
    bit           m_wr  [64];
    int           m_ptr;
    bit           m_hold;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int idx, cnt;
        if (rst) begin
            for (int k = 0; k < 64; k++) begin m_mem[k] = '0; m_wr[k] = 1'b0; end
            m_ptr = 0; m_hold = 1'b0;
        end else if (release_i) begin
            for (int k = 0; k < 64; k++) m_wr[k] = 1'b0;
            m_ptr = 0; m_hold = 1'b0;
        end else if (in_valid && !m_hold) begin
            idx = (AUTO_EN && auto) ? m_ptr : int'(S);
            m_mem[idx] = D;
            m_wr[idx]  = 1'b1;
            if (AUTO_EN && auto) m_ptr = (m_ptr + 1) % 64;
            cnt = 0;
            for (int k = 0; k < 64; k++) cnt += m_wr[k];
            if (cnt == 64) m_hold = 1'b1;
        end
    endtask

    task automatic check_model();
        logic [64*N-1:0] ef;
        logic [63:0]     ev;
        for (int k = 0; k < 64; k++) begin ef[k*N +: N] = m_mem[k]; ev[k] = m_wr[k]; end
        chk("F", F, ef);
        chk("vmask", vmask, ev);
        chk("full", full, m_hold);
        chk("in_ready", in_ready, !m_hold);
        chk("wr_ptr", wr_ptr, m_ptr[5:0]);
    endtask

    // Drive at negedge, clock, step model, compare #1 after the edge.
    task automatic cyc(input bit r, input logic [N-1:0] d, input logic [5:0] s,
                       input bit a, input bit v, input bit rl);
        rst = r; D = d; S = s; auto = a; in_valid = v; release_i = rl;
        @(posedge clk);
        model_step();
        #1;
        check_model();
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] slot(input int k);
        return F[k*N +: N];
    endfunction

    typedef struct {
        bit          r;
        logic [7:0]  d;
        logic [5:0]  s;
        bit          v, rl;
        logic [63:0] ev;
        bit          ef;
        int          k;
        logic [7:0]  es;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1, 8'h00, 6'd0,  0, 0, 64'h0,                        0, 37, 8'h00};
        tbl[1] = '{0, 8'h00, 6'd0,  0, 0, 64'h0,                        0, 37, 8'h00};
        tbl[2] = '{0, 8'hA5, 6'd37, 1, 0, 64'h1 << 37,                  0, 37, 8'hA5};
        tbl[3] = '{0, 8'h3C, 6'd37, 1, 0, 64'h1 << 37,                  0, 37, 8'h3C};
        tbl[4] = '{0, 8'h11, 6'd0,  1, 0, (64'h1 << 37) | 64'h1,        0, 0,  8'h11};
        tbl[5] = '{0, 8'h77, 6'd5,  1, 1, 64'h0,                        0, 5,  8'h00};
        tbl[6] = '{0, 8'hFF, 6'd37, 0, 0, 64'h0,                        0, 37, 8'h3C};

        rst = 1'b1; D = '0; S = '0; auto = 1'b0; in_valid = 1'b0; release_i = 1'b0;
        for (int k = 0; k < 64; k++) begin m_mem[k] = '0; m_wr[k] = 1'b0; end
        m_ptr = 0; m_hold = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].r, tbl[i].d, tbl[i].s, 1'b0, tbl[i].v, tbl[i].rl);
            chk($sformatf("tbl%0d_vmask", i), vmask, tbl[i].ev);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].ef);
            chk($sformatf("tbl%0d_slot", i), slot(tbl[i].k), tbl[i].es);
        end

        // Auto fill of all 64 slots; S tracks k so the data layout is the same without auto.
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 64; k++) cyc(0, N'(k), 6'(k), 1, 1, 0);
        chk("fill_full", full, 1'b1);
        chk("fill_ready", in_ready, 1'b0);
        chk("fill_ptr", wr_ptr, 6'd0);
        chk("fill_slot63", slot(63), 8'd63);
        chk("fill_vmask", vmask, {64{1'b1}});

        // HOLD ignores writes, then release empties the flags but keeps data.
        cyc(0, 8'hFF, 6'd3, 1, 1, 0);
        chk("hold_slot3", slot(3), 8'd3);
        chk("hold_full", full, 1'b1);
        cyc(0, 8'h00, 6'd0, 0, 0, 1);
        chk("rel_vmask", vmask, 64'h0);
        chk("rel_full", full, 1'b0);
        chk("rel_ready", in_ready, 1'b1);
        chk("rel_slot10", slot(10), 8'd10);

        // Release collides with a write after 5 auto writes.
        for (int k = 0; k < 5; k++) cyc(0, N'(8'h40 + k), 6'(k), 1, 1, 0);
        cyc(0, 8'hEE, 6'd5, 1, 1, 1);
        chk("col_vmask", vmask, 64'h0);
        chk("col_ptr", wr_ptr, 6'd0);
        chk("col_slot5", slot(5), 8'd5);

        // Reset mid-fill at pointer 20, with a write pending in the same cycle.
        for (int k = 0; k < 20; k++) cyc(0, N'(8'h80 + k), 6'(k), 1, 1, 0);
        cyc(1, 8'h55, 6'd20, 1, 1, 0);
        chk("rst_F", F, '0);
        chk("rst_vmask", vmask, 64'h0);
        chk("rst_ptr", wr_ptr, 6'd0);
        chk("rst_ready", in_ready, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), N'($urandom), 6'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
